rsa_modexp_ctrl: RTL and testbench

Sequencer for the Montgomery-multiplier datapath inside the RSA project wrapper. It runs left-to-right square-and-multiply modular exponentiation for one command. The exponent, its bit length and start come from the CSR block (COMMAND/R2/R6); done feeds STATUS bit 0. It issues one multiplication at a time to a shared mont_mul core through a start/done handshake, and drives the operand-select and destination write-enable lines of the surrounding register file.

---
 rtl/rsa_ctrl_pkg.sv | 26 ++
 rtl/rsa_exp_scanner.sv | 51 +++++
 rtl/rsa_modexp_ctrl.sv | 140 ++++++++++++++
 tb/tb_rsa_modexp_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_ctrl_pkg.sv
// Shared types and constants for the RSA modular-exponentiation sequencer.
package rsa_ctrl_pkg;

  localparam int E_WIDTH_DEF = 1024;
  localparam int LEN_W_DEF   = 11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SQR  = 3'd2,
    ST_MUL  = 3'd3,
    ST_POST = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // Operand A select
  localparam logic A_SEL_X = 1'b0;
  localparam logic A_SEL_A = 1'b1;

  // Operand B select
  localparam logic [1:0] B_SEL_R2  = 2'd0;
  localparam logic [1:0] B_SEL_A   = 2'd1;
  localparam logic [1:0] B_SEL_XT  = 2'd2;
  localparam logic [1:0] B_SEL_ONE = 2'd3;

endpackage

// File: rtl/rsa_exp_scanner.sv
// Holds the captured exponent and the bit cursor walked MSB-first by the FSM.
module rsa_exp_scanner
  import rsa_ctrl_pkg::*;
#(
  parameter int E_WIDTH = E_WIDTH_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               load,
  input  logic               dec,
  input  logic [E_WIDTH-1:0] exp_in,
  input  logic [LEN_W-1:0]   exp_len,
  output logic               cur_bit,
  output logic               last,
  output logic               zero_len
);

  localparam int CNT_W = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;
  localparam logic [LEN_W-1:0] E_WIDTH_L = LEN_W'(E_WIDTH);

  logic [E_WIDTH-1:0] exp_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               zero_len_reg;
  logic [LEN_W-1:0]   len_clamped;

  // Lengths beyond the register width scan the full exponent.
  always_comb begin
    len_clamped = (exp_len > E_WIDTH_L) ? E_WIDTH_L : exp_len;
  end

  // Capture exponent and cursor on load; step the cursor down on dec.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exp_reg      <= '0;
      cnt_reg      <= '0;
      zero_len_reg <= 1'b0;
    end else if (load) begin
      exp_reg      <= exp_in;
      zero_len_reg <= (len_clamped == '0);
      cnt_reg      <= (len_clamped == '0) ? '0 : CNT_W'(len_clamped - LEN_W'(1));
    end else if (dec) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign cur_bit  = exp_reg[cnt_reg];
  assign last     = (cnt_reg == '0);
  assign zero_len = zero_len_reg;

endmodule

// File: rtl/rsa_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving a shared Montgomery
// multiplier through a start/done handshake.
module rsa_modexp_ctrl
  import rsa_ctrl_pkg::*;
#(
  parameter int E_WIDTH = E_WIDTH_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [E_WIDTH-1:0] exp_in,
  input  logic [LEN_W-1:0]   exp_len,
  output logic               busy,
  output logic               done,
  output logic               mm_start,
  output logic               mm_a_sel,
  output logic [1:0]         mm_b_sel,
  input  logic               mm_done,
  output logic               xt_we,
  output logic               a_we,
  output logic               res_we
);

  state_t state_reg, state_next;
  // Set once the current op's multiplication has been launched.
  logic   issued_reg, issued_next;
  logic   scan_load, scan_dec;
  logic   cur_bit, last, zero_len;

  rsa_exp_scanner #(
    .E_WIDTH (E_WIDTH),
    .LEN_W   (LEN_W)
  ) u_scanner (
    .clk      (clk),
    .resetn   (resetn),
    .load     (scan_load),
    .dec      (scan_dec),
    .exp_in   (exp_in),
    .exp_len  (exp_len),
    .cur_bit  (cur_bit),
    .last     (last),
    .zero_len (zero_len)
  );

  // State and launch-flag registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= ST_IDLE;
      issued_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      issued_reg <= issued_next;
    end
  end

  // Next-state, operand selects and same-cycle write enables.
  always_comb begin
    state_next  = state_reg;
    issued_next = 1'b0;
    scan_load   = 1'b0;
    scan_dec    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    mm_start    = 1'b0;
    mm_a_sel    = A_SEL_X;
    mm_b_sel    = B_SEL_R2;
    xt_we       = 1'b0;
    a_we        = 1'b0;
    res_we      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          scan_load  = 1'b1;
          state_next = ST_PRE;
        end
      end
      ST_PRE: begin
        busy        = 1'b1;
        mm_start    = !issued_reg;
        issued_next = !mm_done;
        if (mm_done) begin
          xt_we      = 1'b1;
          state_next = zero_len ? ST_POST : ST_SQR;
        end
      end
      ST_SQR: begin
        busy        = 1'b1;
        mm_start    = !issued_reg;
        issued_next = !mm_done;
        mm_a_sel    = A_SEL_A;
        mm_b_sel    = B_SEL_A;
        if (mm_done) begin
          a_we = 1'b1;
          if (cur_bit) begin
            state_next = ST_MUL;
          end else if (last) begin
            state_next = ST_POST;
          end else begin
            scan_dec   = 1'b1;
            state_next = ST_SQR;
          end
        end
      end
      ST_MUL: begin
        busy        = 1'b1;
        mm_start    = !issued_reg;
        issued_next = !mm_done;
        mm_a_sel    = A_SEL_A;
        mm_b_sel    = B_SEL_XT;
        if (mm_done) begin
          a_we = 1'b1;
          if (last) begin
            state_next = ST_POST;
          end else begin
            scan_dec   = 1'b1;
            state_next = ST_SQR;
          end
        end
      end
      ST_POST: begin
        busy        = 1'b1;
        mm_start    = !issued_reg;
        issued_next = !mm_done;
        mm_a_sel    = A_SEL_A;
        mm_b_sel    = B_SEL_ONE;
        if (mm_done) begin
          res_we     = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (!start) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Self-checking bench for rsa_modexp_ctrl with a fixed-latency mock multiplier.
module tb_rsa_modexp_ctrl;

  localparam int EW = 1024;
  localparam int LW = 11;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [EW-1:0] exp_in;
  logic [LW-1:0] exp_len;
  logic          busy, done, mm_start, mm_a_sel;
  logic [1:0]    mm_b_sel;
  logic          mm_done = 1'b0;
  logic          xt_we, a_we, res_we;

  rsa_modexp_ctrl dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .exp_in   (exp_in),
    .exp_len  (exp_len),
    .busy     (busy),
    .done     (done),
    .mm_start (mm_start),
    .mm_a_sel (mm_a_sel),
    .mm_b_sel (mm_b_sel),
    .mm_done  (mm_done),
    .xt_we    (xt_we),
    .a_we     (a_we),
    .res_we   (res_we)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor / mock-multiplier state
  int cyc = 0;
  int mm_lat = 5;
  int pend = 0;
  bit inject = 1'b0;
  int n_start, n_xt, n_a, n_res, n_mmd, n_done_cyc, n_glitch;
  int done_cyc;
  int prev_code = 0;
  bit prev_start = 1'b0;
  bit done_d = 1'b0;
  int ops[$];
  int exp_ops[$];

  // Per cycle: drive the mock mm_done, then sample the DUT away from the edge.
  always begin
    int code;
    @(posedge clk);
    cyc++;
    #1;
    mm_done = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) mm_done = 1'b1;
    end
    if (inject) begin
      mm_done = 1'b1;
      inject  = 1'b0;
    end
    #1;
    code = int'(mm_a_sel) * 4 + int'(mm_b_sel);
    if (mm_done) n_mmd++;
    if (mm_start) begin
      n_start++;
      ops.push_back(code);
      pend = mm_lat;
    end
    if (xt_we)  n_xt++;
    if (a_we)   n_a++;
    if (res_we) n_res++;
    if (done)   n_done_cyc++;
    if (busy && !mm_start && code != prev_code) n_glitch++;
    if (mm_start && prev_start) n_glitch++;
    if ((xt_we || a_we || res_we) && !mm_done) n_glitch++;
    if (done && !done_d && done_cyc < 0) done_cyc = cyc;
    prev_code  = code;
    prev_start = mm_start;
    done_d     = done;
  end

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Advance to the falling edge of the next cycle.
  task automatic tick();
    @(posedge clk);
    #5;
  endtask

  task automatic clear_counts();
    n_start = 0; n_xt = 0; n_a = 0; n_res = 0; n_mmd = 0;
    n_done_cyc = 0; n_glitch = 0; done_cyc = -1;
    ops.delete();
  endtask

  // Launch one exponentiation; returns cycles from start sample to done rise.
  task automatic run_one(input logic [EW-1:0] e, input logic [LW-1:0] len,
                         input int d, input bit hold, input bit drop_early,
                         output int lat);
    int s_cyc;
    tick();
    clear_counts();
    mm_lat  = d;
    exp_in  = e;
    exp_len = len;
    start   = 1'b1;
    s_cyc   = cyc;
    tick();
    // Scramble the inputs: the run must use the values captured at start.
    exp_in  = ~e;
    exp_len = LW'($urandom_range(0, 2047));
    if (drop_early) start = 1'b0;
    for (int i = 0; i < 4000 && done_cyc < 0; i++) tick();
    if (done_cyc < 0) begin
      chk("done_timeout", 0, 1);
      lat = -1;
    end else begin
      lat = done_cyc - s_cyc;
    end
    if (!hold) begin
      start = 1'b0;
      tick();
    end
  endtask

  // Reference: ops derived straight from the exponent bits.
  task automatic check_run(input string tag, input logic [EW-1:0] e, input int len,
                           input int d, input int lat, input bit one_cycle_done);
    int l, pop, n, bad;
    l   = (len > EW) ? EW : len;
    pop = 0;
    exp_ops.delete();
    exp_ops.push_back(0);               // PRE:  X * R2
    for (int i = l - 1; i >= 0; i--) begin
      exp_ops.push_back(5);             // SQR:  A * A
      if (e[i]) begin
        exp_ops.push_back(6);           // MUL:  A * XT
        pop++;
      end
    end
    exp_ops.push_back(7);               // POST: A * 1
    n = 2 + l + pop;
    chk({tag, "_n_start"}, n_start, n);
    chk({tag, "_xt_we"},   n_xt, 1);
    chk({tag, "_a_we"},    n_a, l + pop);
    chk({tag, "_res_we"},  n_res, 1);
    chk({tag, "_latency"}, lat, n * (d + 1) + 1);
    chk({tag, "_glitch"},  n_glitch, 0);
    bad = 0;
    if (ops.size() != exp_ops.size()) bad = 1;
    else foreach (ops[i]) if (ops[i] != exp_ops[i]) bad = 1;
    chk({tag, "_op_seq"}, bad, 0);
    if (one_cycle_done) chk({tag, "_done_width"}, n_done_cyc, 1);
    $display("run %s: len=%0d D=%0d mults=%0d latency=%0d", tag, len, d, n_start, lat);
  endtask

  typedef struct {
    logic [EW-1:0] e;
    logic [LW-1:0] len;
    int            d;
    int            n_req;
    int            lat_req;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int lat, acc, we_before, n_before;
    logic [EW-1:0] e;

    tbl[0] = '{e: EW'(16'hA6C9), len: 11'd16,   d: 5, n_req: 26,   lat_req: 157};
    tbl[1] = '{e: EW'(1),        len: 11'd1,    d: 5, n_req: 4,    lat_req: 25};
    tbl[2] = '{e: EW'(16'h1234), len: 11'd0,    d: 5, n_req: 2,    lat_req: 13};
    tbl[3] = '{e: '0,            len: 11'd2000, d: 1, n_req: 1028, lat_req: 2057};
    tbl[3].e[EW-1] = 1'b1;
    tbl[3].e[0]    = 1'b1;
    tbl[4] = '{e: EW'(3'b101),   len: 11'd3,    d: 3, n_req: 7,    lat_req: 29};

    resetn = 1'b0; start = 1'b0; exp_in = '0; exp_len = '0;
    clear_counts();
    repeat (3) tick();
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_outs",  {mm_start, mm_a_sel, mm_b_sel, xt_we, a_we, res_we}, 0);
    resetn = 1'b1;
    tick();

    // Table-driven runs
    foreach (tbl[i]) begin
      run_one(tbl[i].e, tbl[i].len, tbl[i].d, 1'b0, 1'b0, lat);
      chk($sformatf("tbl%0d_n_const", i), n_start, tbl[i].n_req);
      chk($sformatf("tbl%0d_lat_const", i), lat, tbl[i].lat_req);
      check_run($sformatf("tbl%0d", i), tbl[i].e, int'(tbl[i].len), tbl[i].d, lat, 1'b1);
      if (i == 1) begin
        acc = (ops.size() == 4) ? (ops[0] * 1000 + ops[1] * 100 + ops[2] * 10 + ops[3]) : -1;
        chk("e1_sel_seq", acc, 567);   // a/b codes: PRE=0, SQR=5, MUL=6, POST=7
      end
      if (i == 2) chk("zero_len_a_we", n_a, 0);
    end

    // Handshake: hold start after done, spurious mm_done in DONE, then drop
    run_one(EW'(3'b110), 11'd3, 2, 1'b1, 1'b0, lat);
    check_run("hold", EW'(3'b110), 3, 2, lat, 1'b0);
    n_before = n_start;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!done || busy) acc++;
    end
    chk("done_held", acc, 0);
    chk("no_rerun", n_start, n_before);
    we_before = n_xt + n_a + n_res;
    inject = 1'b1;
    tick(); tick();
    chk("spur_done_state", done, 1);
    chk("spur_done_we", n_xt + n_a + n_res, we_before);
    start = 1'b0;
    tick();
    chk("drop_done", done, 0);
    chk("drop_busy", busy, 0);
    inject = 1'b1;
    tick(); tick();
    chk("spur_idle_busy", busy, 0);
    chk("spur_idle_we", n_xt + n_a + n_res, we_before);
    run_one(EW'(16'h00F1), 11'd8, 4, 1'b0, 1'b0, lat);
    check_run("rerun", EW'(16'h00F1), 8, 4, lat, 1'b1);

    // Reset during a MUL wait; the in-flight mm_done lands after release
    tick();
    clear_counts();
    mm_lat = 5; exp_in = EW'(16'hA6C9); exp_len = 11'd16; start = 1'b1;
    acc = 0;
    for (int i = 0; i < 500 && !(mm_start && mm_b_sel == 2'd2); i++) tick();
    chk("mul_reached", int'(mm_start && mm_b_sel == 2'd2), 1);
    resetn = 1'b0;
    start  = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    tick();
    resetn = 1'b1;
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy || done || mm_start || mm_a_sel || mm_b_sel != 2'd0) acc++;
    end
    chk("post_rst_mock_done", int'(n_mmd > 0), 1);
    chk("post_rst_outs", acc, 0);
    chk("post_rst_we", n_xt + n_a + n_res, 0);
    chk("post_rst_start", n_start, 0);

    // Random runs against the reference
    for (int r = 0; r < 8; r++) begin
      int d, len;
      e = '0;
      e[31:0]  = $urandom;
      e[63:32] = $urandom;
      d   = $urandom_range(1, 20);
      len = $urandom_range(0, 48);
      run_one(e, LW'(len), d, 1'b0, r[0], lat);
      check_run($sformatf("rnd%0d", r), e, len, d, lat, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
